// File: rtl/lsu_mem_port.sv
// lsu_mem_port: data-memory port for the RISC-V core.
// Turns decoder memory-stage controls into a single req/ack word-bus
// transaction, builds byte strobes and lane-replicated store data, and
// extracts and extends load data. Illegal accesses and bus timeouts are
// reported on access_err.
module lsu_mem_port #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Mem_mode,
    input  logic        Mem_read_us,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        access_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_reg;
    logic [CW-1:0]  cnt_reg;
    logic [1:0]     off_reg;
    logic [2:0]     mode_reg;
    logic           us_reg;
    logic           load_reg;

    logic           access;
    logic           legal;
    logic [3:0]     strb;
    logic [31:0]    wdata_rep;
    logic [7:0]     rd_lane [4];
    logic [7:0]     byte_sel;
    logic [15:0]    half_sel;
    logic [31:0]    load_ext;

    // Split the read word into byte lanes for load extraction.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rd_lane[gi] = bus_rdata[8*gi +: 8];
    end

    // Decode the incoming request: legality, strobes and replicated data.
    always_comb begin
        access = MemRead | MemWrite;
        legal  = 1'b1;
        if (MemRead && MemWrite)
            legal = 1'b0;
        if (!(Mem_mode == 3'b001 || Mem_mode == 3'b010 || Mem_mode == 3'b100))
            legal = 1'b0;
        if (Mem_mode == 3'b010 && addr[0])
            legal = 1'b0;
        if (Mem_mode == 3'b100 && addr[1:0] != 2'b00)
            legal = 1'b0;
        case (Mem_mode)
            3'b001: begin
                strb      = 4'b0001 << addr[1:0];
                wdata_rep = {4{wdata[7:0]}};
            end
            3'b010: begin
                strb      = 4'b0011 << {addr[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                strb      = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

    // Select and extend the load lane using the latched offset, size and signedness.
    always_comb begin
        byte_sel = rd_lane[off_reg];
        half_sel = off_reg[1] ? {rd_lane[3], rd_lane[2]} : {rd_lane[1], rd_lane[0]};
        case (mode_reg)
            3'b001:  load_ext = {{24{~us_reg & byte_sel[7]}}, byte_sel};
            3'b010:  load_ext = {{16{~us_reg & half_sel[15]}}, half_sel};
            default: load_ext = bus_rdata;
        endcase
    end

    // Stall while a request is being accepted or is outstanding on the bus.
    always_comb begin
        stall = (state_reg == REQ) || (state_reg == IDLE && access);
    end

    // Transaction FSM with registered bus and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            off_reg     <= 2'b00;
            mode_reg    <= 3'b000;
            us_reg      <= 1'b0;
            load_reg    <= 1'b0;
            rdata       <= 32'h0;
            rdata_valid <= 1'b0;
            access_err  <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'h0;
            bus_wstrb   <= 4'h0;
            bus_wdata   <= 32'h0;
        end else begin
            rdata_valid <= 1'b0;
            access_err  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (access) begin
                        off_reg   <= addr[1:0];
                        mode_reg  <= Mem_mode;
                        us_reg    <= Mem_read_us;
                        load_reg  <= MemRead & ~MemWrite;
                        bus_we    <= MemWrite;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_wstrb <= MemWrite ? strb : 4'b0000;
                        bus_wdata <= wdata_rep;
                        cnt_reg   <= '0;
                        if (legal) begin
                            bus_req   <= 1'b1;
                            state_reg <= REQ;
                        end else begin
                            // Rejected up front: report and skip the bus entirely.
                            access_err <= 1'b1;
                            state_reg  <= DONE;
                        end
                    end
                end
                REQ: begin
                    // An ack in the last allowed cycle still counts as success.
                    if (bus_ack) begin
                        bus_req   <= 1'b0;
                        state_reg <= DONE;
                        if (load_reg) begin
                            rdata       <= load_ext;
                            rdata_valid <= 1'b1;
                        end
                    end else if (cnt_reg == TMO_LAST) begin
                        bus_req    <= 1'b0;
                        access_err <= 1'b1;
                        state_reg  <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Testbench for lsu_mem_port: directed vector table, a reset-abort sequence,
// and randomized accesses checked against a byte-level reference model.
module tb_lsu_mem_port;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead, MemWrite, Mem_read_us;
    logic [2:0]  Mem_mode;
    logic [31:0] addr, wdata;
    logic        stall, rdata_valid, access_err, bus_req, bus_we, bus_ack;
    logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;

    int checks = 0;
    int errors = 0;
    int txn_no = 0;
    logic [31:0] model_rdata = 32'h0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  mode;
        logic        us;
        logic [31:0] a;
        logic [31:0] wd;
        int          ack_at;     // cycle (from request) at which ack is driven; 0 = never
        logic [31:0] rword;
        int          exp_req;    // number of cycles bus_req must be high
        logic        exp_err;
        logic        exp_valid;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t tbl [14];

    lsu_mem_port #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemRead(MemRead), .MemWrite(MemWrite), .Mem_mode(Mem_mode),
        .Mem_read_us(Mem_read_us), .addr(addr), .wdata(wdata),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
        .access_err(access_err), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Reference model: derive expectations from access size in bytes.
    function automatic vec_t make_rand();
        vec_t v;
        int nb, off, r;
        logic legal, ok;
        logic [31:0] lane, mask, val;
        r = $urandom_range(0, 19);
        v.rd = (r < 10) || (r == 0);
        v.wr = (r >= 10) || (r == 0);
        r = $urandom_range(0, 9);
        if (r < 3)      v.mode = 3'b001;
        else if (r < 6) v.mode = 3'b010;
        else if (r < 9) v.mode = 3'b100;
        else            v.mode = 3'($urandom_range(0, 7));
        v.us = 1'($urandom_range(0, 1));
        nb = (v.mode == 3'b001) ? 1 : (v.mode == 3'b010) ? 2 : 4;
        v.a = $urandom;
        if ($urandom_range(0, 9) < 7) v.a = v.a & ~32'(nb - 1);
        v.wd = $urandom;
        v.rword = $urandom;
        off = int'(v.a % 4);
        legal = !(v.rd && v.wr) && ($countones(v.mode) == 1) && (v.a % nb == 0);
        r = $urandom_range(0, 19);
        if (r < 16) v.ack_at = $urandom_range(1, 4);
        else case (r)
            16: v.ack_at = 0;
            17: v.ack_at = T - 1;
            18: v.ack_at = T;
            default: v.ack_at = T + 1;
        endcase
        ok = legal && v.ack_at >= 1 && v.ack_at <= T;
        v.exp_req = !legal ? 0 : (ok ? v.ack_at : T);
        v.exp_err = !ok;
        v.exp_valid = ok && v.rd;
        v.exp_strb = v.wr ? 4'(((1 << nb) - 1) << off) : 4'h0;
        for (int i = 0; i < 4; i++) v.exp_wd[8*i +: 8] = v.wd[8*(i % nb) +: 8];
        lane = v.rword >> (8 * off);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
        val = lane & mask;
        if (!v.us && nb < 4 && val[8*nb-1]) val = val | ~mask;
        v.exp_rdata = v.exp_valid ? val : model_rdata;
        return v;
    endfunction

    // Drive one access, play the memory side, and check every cycle of it.
    task automatic run_access(input vec_t v);
        int cyc, reqs;
        bit done;
        @(negedge clk);
        MemRead = v.rd; MemWrite = v.wr; Mem_mode = v.mode; Mem_read_us = v.us;
        addr = v.a; wdata = v.wd; bus_ack = 1'b0;
        #1;
        chk($sformatf("t%0d stall_c0", txn_no), 32'(stall), 32'h1);
        chk($sformatf("t%0d req_c0", txn_no), 32'(bus_req), 32'h0);
        cyc = 0; reqs = 0; done = 0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            bus_ack   = (cyc == v.ack_at);
            bus_rdata = (cyc == v.ack_at) ? v.rword : $urandom;
            #1;
            if (bus_req) begin
                reqs++;
                chk($sformatf("t%0d stall_req", txn_no), 32'(stall), 32'h1);
                chk($sformatf("t%0d bus_we", txn_no), 32'(bus_we), 32'(v.wr));
                chk($sformatf("t%0d bus_addr", txn_no), bus_addr, v.a & 32'hFFFF_FFFC);
                chk($sformatf("t%0d bus_wstrb", txn_no), 32'(bus_wstrb), 32'(v.exp_strb));
                if (v.wr) chk($sformatf("t%0d bus_wdata", txn_no), bus_wdata, v.exp_wd);
            end else begin
                done = 1;
            end
        end
        chk($sformatf("t%0d done_cycle", txn_no), 32'(cyc), 32'(v.exp_req + 1));
        chk($sformatf("t%0d req_cycles", txn_no), 32'(reqs), 32'(v.exp_req));
        chk($sformatf("t%0d stall_done", txn_no), 32'(stall), 32'h0);
        chk($sformatf("t%0d rdata_valid", txn_no), 32'(rdata_valid), 32'(v.exp_valid));
        chk($sformatf("t%0d access_err", txn_no), 32'(access_err), 32'(v.exp_err));
        chk($sformatf("t%0d rdata", txn_no), rdata, v.exp_rdata);
        model_rdata = v.exp_rdata;
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0; bus_ack = 1'b0;
        #1;
        chk($sformatf("t%0d pulse_end", txn_no), 32'({rdata_valid, access_err, bus_req, stall}), 32'h0);
        chk($sformatf("t%0d rdata_hold", txn_no), rdata, model_rdata);
        $display("txn %0d rd=%0b wr=%0b mode=%03b addr=%08h ack_at=%0d req_cycles=%0d err=%0b valid=%0b rdata=%08h",
                 txn_no, v.rd, v.wr, v.mode, v.a, v.ack_at, reqs, access_err, v.exp_valid, rdata);
        txn_no++;
    endtask

    initial begin
        //         rd    wr    mode    us    addr          wdata         ack rword         req err   valid exp_rdata     strb   exp_wd
        tbl[0]  = '{1'b1,1'b0,3'b001,1'b0,32'h0000_1003,32'h0,        1, 32'h80FF_1234, 1, 1'b0,1'b1,32'hFFFF_FF80,4'h0, 32'h0};
        tbl[1]  = '{1'b1,1'b0,3'b010,1'b1,32'h0000_2002,32'h0,        3, 32'hBEEF_0000, 3, 1'b0,1'b1,32'h0000_BEEF,4'h0, 32'h0};
        tbl[2]  = '{1'b0,1'b1,3'b001,1'b0,32'h0000_3001,32'h0000_00AB,1, 32'h0,         1, 1'b0,1'b0,32'h0000_BEEF,4'b0010,32'hABAB_ABAB};
        tbl[3]  = '{1'b0,1'b1,3'b100,1'b0,32'h0000_3004,32'h1234_5678,2, 32'h0,         2, 1'b0,1'b0,32'h0000_BEEF,4'b1111,32'h1234_5678};
        tbl[4]  = '{1'b1,1'b0,3'b100,1'b0,32'h0000_4002,32'h0,        1, 32'hDEAD_DEAD, 0, 1'b1,1'b0,32'h0000_BEEF,4'h0, 32'h0};
        tbl[5]  = '{1'b1,1'b1,3'b100,1'b0,32'h0000_4000,32'h0,        1, 32'h1111_1111, 0, 1'b1,1'b0,32'h0000_BEEF,4'h0, 32'h0};
        tbl[6]  = '{1'b1,1'b0,3'b011,1'b0,32'h0000_4000,32'h0,        1, 32'h2222_2222, 0, 1'b1,1'b0,32'h0000_BEEF,4'h0, 32'h0};
        tbl[7]  = '{1'b1,1'b0,3'b000,1'b0,32'h0000_4000,32'h0,        1, 32'h3333_3333, 0, 1'b1,1'b0,32'h0000_BEEF,4'h0, 32'h0};
        tbl[8]  = '{1'b1,1'b0,3'b010,1'b0,32'h0000_5002,32'h0,        2, 32'h8001_1234, 2, 1'b0,1'b1,32'hFFFF_8001,4'h0, 32'h0};
        tbl[9]  = '{1'b1,1'b0,3'b001,1'b1,32'h0000_5001,32'h0,        1, 32'h0000_F700, 1, 1'b0,1'b1,32'h0000_00F7,4'h0, 32'h0};
        tbl[10] = '{1'b0,1'b1,3'b010,1'b0,32'h0000_6002,32'h0000_CAFE,T, 32'h0,         T, 1'b0,1'b0,32'h0000_00F7,4'b1100,32'hCAFE_CAFE};
        tbl[11] = '{1'b0,1'b1,3'b010,1'b0,32'h0000_6000,32'h0000_1234,0, 32'h0,         T, 1'b1,1'b0,32'h0000_00F7,4'b0011,32'h1234_1234};
        tbl[12] = '{1'b1,1'b0,3'b100,1'b1,32'h0000_7000,32'h0,        1, 32'hDEAD_BEEF, 1, 1'b0,1'b1,32'hDEAD_BEEF,4'h0, 32'h0};
        tbl[13] = '{1'b1,1'b0,3'b010,1'b1,32'h0000_7002,32'h0,        T+1,32'h5555_5555,T, 1'b1,1'b0,32'hDEAD_BEEF,4'h0, 32'h0};

        rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Mem_mode = 3'b000; Mem_read_us = 1'b0;
        addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
        #1;
        chk("reset_ctrl", 32'({stall, bus_req, bus_we, rdata_valid, access_err}), 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_bus_addr", bus_addr, 32'h0);
        chk("reset_bus_wdata", bus_wdata, 32'h0);
        chk("reset_bus_wstrb", 32'(bus_wstrb), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 14; i++) run_access(tbl[i]);

        // Reset while the request is outstanding: bus_req must drop at once.
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b0; Mem_mode = 3'b100; addr = 32'h0000_8000; bus_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mid_req_before", 32'(bus_req), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req_drop", 32'(bus_req), 32'h0);
        chk("rst_mid_rdata", rdata, 32'h0);
        model_rdata = 32'h0;
        MemRead = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hA5A5_A5A5;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        chk("late_ack_ignored", 32'({rdata_valid, access_err, bus_req, stall}), 32'h0);
        chk("late_ack_rdata", rdata, 32'h0);
        @(negedge clk);
        #1;
        chk("late_ack_idle", 32'({rdata_valid, bus_req}), 32'h0);
        run_access('{1'b1,1'b0,3'b100,1'b0,32'h0000_8004,32'h0,2,32'h0BAD_F00D,2,1'b0,1'b1,32'h0BAD_F00D,4'h0,32'h0});

        // Randomized accesses against the reference model.
        for (int n = 0; n < 150; n++) run_access(make_rand());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Data-memory port for the RISC-V core: consumes the memory-stage control bits produced by the instruction decoder (MemRead, MemWrite, Mem_mode, Mem_read_us) plus address and store data, and runs a req/ack transaction on the word-wide data-memory bus. It generates byte strobes and lane-replicated store data. It extracts and sign- or zero-extends load data, stalls the pipeline while a transaction is outstanding, and flags illegal, misaligned or timed-out accesses.

## Interface
- TIMEOUT_CYC, 16, maximum cycles bus_req stays high without bus_ack before the access is aborted (≥2)
- clk  input  1  clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- MemRead  input  1  load request from decoder
- MemWrite  input  1  store request from decoder
- Mem_mode  input  3  one-hot size: bit0 byte, bit1 half, bit2 word
- Mem_read_us  input  1  1 = zero-extend load, 0 = sign-extend
- addr  input  32  byte address from ALU
- wdata  input  32  store data (rs2)
- stall  output  1  hold memory stage and earlier stages
- rdata  output  32  extended load result, held until next completion
- rdata_valid  output  1  one-cycle pulse, successful load result on rdata
- access_err  output  1  one-cycle pulse, access rejected or aborted
- bus_req  output  1  transaction request
- bus_we  output  1  1 = write
- bus_addr  output  32  word address ({addr[31:2],2'b00})
- bus_wstrb  output  4  byte-lane write enables (0000 on reads)
- bus_wdata  output  32  lane-replicated store data
- bus_ack  input  1  memory completes transaction this cycle
- bus_rdata  input  32  read word, valid with bus_ack

## Operation
- FSM states: IDLE, REQ, DONE. Reset → IDLE.
- Access present = MemRead | MemWrite.
- IDLE, no access → stay; stall=0.
- IDLE, access present → stall=1 combinationally; request latched (addr, size, us, we, strobes, data) at the edge.
  - Legal → REQ.
  - Illegal → DONE with error flag set, no bus activity.
- Illegal: MemRead & MemWrite; Mem_mode not exactly one-hot; half with addr[0]=1; word with addr[1:0]≠00.
- REQ: bus_req=1, stall=1.
  - bus_ack=1 → DONE; load data captured.
  - No ack and timeout counter = TIMEOUT_CYC−1 → DONE with error flag.
- DONE: stall=0, bus_req=0.
  - rdata_valid=1 iff successful load.
  - access_err=1 iff error flag.
  - → IDLE unconditionally. The pipeline advances on this edge, so a new access is sampled only in IDLE.
- Strobes:
  - byte: 0001<<addr[1:0]
  - half: 0011<<{addr[1],1'b0}
  - word: 1111
- Store data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load extraction uses latched addr/size/us.
  - Byte lane = bus_rdata[8*addr[1:0]+:8]; half lane = bus_rdata[16*addr[1]+:16].
  - Extend to 32 bits with zeros if us=1, else replicate the MSB.
  - Word loads ignore us.
- Failed loads and stores leave rdata unchanged.
- Timeout counter clears on entry to REQ and increments each REQ cycle without ack.
- bus_ack outside REQ is ignored.

## Timing
- Reset values: state IDLE; bus_req, bus_we, rdata_valid, access_err = 0; bus_addr, bus_wstrb, bus_wdata, rdata = 0. stall follows inputs, so it is 0 with no access.
- Async reset mid-transaction drops bus_req immediately and discards the access. A late bus_ack after reset is ignored.
- Legal access at cycle 0, ack at cycle k≥1: bus_req high cycles 1..k, stall high cycles 0..k, DONE at k+1.
  - Minimum: 2 stall cycles; result in cycle 2.
- Illegal access at cycle 0: stall high cycle 0 only; access_err pulse cycle 1; bus_req never asserted.
- Timeout: bus_req high exactly TIMEOUT_CYC cycles, then access_err pulse.
- Ack in the final timeout cycle counts as success (ack wins).
- Bus outputs are registered and stable for the whole REQ phase. Memory may hold ack low indefinitely, up to the timeout.

## Test plan
- LB addr=0x1003, us=0, bus_rdata=0x80FF_1234, ack 1 cycle after req → rdata=0xFFFF_FF80, rdata_valid pulse cycle 2, stall cycles 0–1.
- LHU addr=0x2002, bus_rdata=0xBEEF_0000, ack delayed 3 cycles → bus_addr=0x2000, rdata=0x0000_BEEF, stall 4 cycles.
- SB addr=0x3001, wdata=0x0000_00AB → bus_we=1, bus_wstrb=0010, bus_wdata=0xABAB_ABAB; SW addr=0x3004 → wstrb=1111; no rdata_valid.
- LW addr=0x4002 → no bus_req, access_err pulse cycle 1, rdata unchanged. MemRead=MemWrite=1 gives the same. Mem_mode=011 gives the same.
- SH with bus_ack held low, TIMEOUT_CYC=16 → bus_req high 16 cycles, then access_err. Repeat with ack in cycle 16 → success, no error.
- rst_n low during REQ → bus_req 0 same cycle; ack after release ignored; next LW completes normally.
